pipeline_stall_ctrl: RTL and testbench

Central sequencing controller for the 5-stage RISC-V pipeline. It takes the load-use stall request from the hazard/forwarding unit, the branch/jump redirect resolved in EX, and the data-memory ready handshake, and arbitrates among them to drive the pipeline-register write enables, flush and bubble controls. It also drains the pipeline on a halt instruction (decoded in ID) and keeps saturating performance counters.

---
 rtl/pipeline_stall_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
`timescale 1ns/1ps
// Pipeline sequencing controller: arbitrates freeze / redirect / load-use / halt
// into pipeline-register enables, drains the pipe on halt, keeps saturating counters.
module pipeline_stall_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_drain_cnt;
    logic [2:0]       w_next_drain_cnt;

    logic             w_freeze;
    logic             w_inc_cycle;
    logic             w_inc_stall;
    logic             w_inc_flush;
    logic             w_inc_freeze;

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    assign w_freeze = dmem_req & ~dmem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain_cnt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;
        case (r_state)
            S_RUN: begin
                if (!w_freeze && !branch_taken && !load_use_stall && halt_req) begin
                    w_next_state     = S_DRAIN;
                    w_next_drain_cnt = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                // A frozen cycle does not advance the halt toward WB, so the count holds.
                if (!w_freeze) begin
                    if (r_drain_cnt <= 3'd1) begin
                        w_next_state     = S_HALTED;
                        w_next_drain_cnt = 3'd0;
                    end else begin
                        w_next_drain_cnt = r_drain_cnt - 3'd1;
                    end
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state     = S_RUN;
                w_next_drain_cnt = 3'd0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        w_inc_cycle  = 1'b0;
        w_inc_stall  = 1'b0;
        w_inc_flush  = 1'b0;
        w_inc_freeze = 1'b0;
        case (r_state)
            S_RUN: begin
                w_inc_cycle = 1'b1;
                if (w_freeze) begin
                    pipe_freeze  = 1'b1;
                    w_inc_freeze = 1'b1;
                end else if (branch_taken) begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_inc_flush  = 1'b1;
                end else if (load_use_stall) begin
                    id_ex_bubble = 1'b1;
                    w_inc_stall  = 1'b1;
                end else if (halt_req) begin
                    // Halt moves into EX while fetch stops; IF/ID gets a NOP behind it.
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                end else begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                end
            end
            S_DRAIN: begin
                w_inc_cycle = 1'b1;
                if (w_freeze) begin
                    pipe_freeze  = 1'b1;
                    w_inc_freeze = 1'b1;
                end else begin
                    id_ex_bubble = 1'b1;
                end
            end
            default: begin
                pipe_freeze = 1'b1;
            end
        endcase
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pipe_freeze  = 1'b1;
            w_inc_cycle  = 1'b0;
            w_inc_stall  = 1'b0;
            w_inc_flush  = 1'b0;
            w_inc_freeze = 1'b0;
        end
    end

    assign halted = (r_state == S_HALTED);

    // Saturating counters: each holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_inc_cycle && (r_cycle_cnt != CNT_MAX))
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_inc_stall && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_inc_flush && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_inc_freeze && (r_freeze_cnt != CNT_MAX))
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
        end
    end

    assign cycle_count  = r_cycle_cnt;
    assign stall_count  = r_stall_cnt;
    assign flush_count  = r_flush_cnt;
    assign freeze_count = r_freeze_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pipeline_stall_ctrl: inputs change on the falling edge,
// outputs are sampled 1ns later, expected values are hand-computed.
module tb_pipeline_stall_ctrl;

    logic        clk;
    logic        reset_n;
    logic        load_use_stall, branch_taken, halt_req, dmem_req, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted;
    logic [31:0] cycle_count, stall_count, flush_count, freeze_count;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .halt_req       (halt_req),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .pipe_freeze    (pipe_freeze),
        .halted         (halted),
        .cycle_count    (cycle_count),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .freeze_count   (freeze_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: apply inputs at the falling edge, settle, then checks follow.
    task automatic drive(input logic lus, input logic br, input logic hlt,
                         input logic req, input logic rdy);
        @(negedge clk);
        load_use_stall = lus;
        branch_taken   = br;
        halt_req       = hlt;
        dmem_req       = req;
        dmem_ready     = rdy;
        #1;
    endtask

    // Control vector {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
            {27'd0, exp});
    endtask

    initial begin
        reset_n = 1'b1;
        load_use_stall = 0; branch_taken = 0; halt_req = 0; dmem_req = 0; dmem_ready = 0;
        #2 reset_n = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            chk_ctl("reset_ctl", 5'b00001);
            chk("reset_halted", halted, 0);
        end
        chk("reset_cycle", cycle_count, 0);

        // Release: cycle 0 of RUN
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_ctl("release_ctl", 5'b11000);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);
        chk("idle_cycle10", cycle_count, 10);
        chk("idle_stall0", stall_count, 0);
        chk("idle_flush0", flush_count, 0);
        chk("idle_freeze0", freeze_count, 0);

        // Cycle 11: load-use pulse
        drive(1, 0, 0, 0, 0);
        chk_ctl("lus_ctl", 5'b00010);
        drive(0, 0, 0, 0, 0);                 // cycle 12
        chk_ctl("lus_after_ctl", 5'b11000);
        chk("lus_stall1", stall_count, 1);

        // Cycle 13: branch beats load-use
        drive(1, 1, 0, 0, 0);
        chk_ctl("br_lus_ctl", 5'b11110);
        drive(0, 0, 0, 0, 0);                 // cycle 14
        chk("br_flush1", flush_count, 1);
        chk("br_stall_unchanged", stall_count, 1);
        chk("cycle14", cycle_count, 14);

        // Cycles 15-18: memory wait masks the branch
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1, 0);
            chk_ctl("freeze_ctl", 5'b00001);
        end
        drive(0, 1, 0, 1, 1);                 // cycle 19: ready ends freeze, flush issues
        chk_ctl("ready_br_ctl", 5'b11110);
        chk("freeze4", freeze_count, 4);
        chk("flush_before", flush_count, 1);
        drive(0, 0, 0, 0, 0);                 // cycle 20
        chk("flush2", flush_count, 2);
        chk("freeze_still4", freeze_count, 4);

        // Cycle 21 (t): halt accepted
        drive(0, 0, 1, 0, 0);
        chk_ctl("halt_ctl", 5'b01100);
        chk("cycle21", cycle_count, 21);
        drive(1, 1, 1, 0, 0);                 // t+1: DRAIN ignores branch/stall/halt
        chk_ctl("drain_ctl", 5'b00010);
        chk("drain_halted0", halted, 0);
        drive(0, 0, 0, 1, 0);                 // t+2: frozen
        chk_ctl("drain_freeze_ctl", 5'b00001);
        drive(0, 0, 0, 1, 0);                 // t+3: frozen
        drive(0, 0, 0, 0, 0);                 // t+4
        chk_ctl("drain_ctl2", 5'b00010);
        drive(0, 0, 0, 0, 0);                 // t+5: last drain cycle
        chk("drain_last_halted0", halted, 0);
        drive(0, 0, 0, 0, 0);                 // t+6
        chk("halted_t6", halted, 1);
        chk_ctl("halted_ctl", 5'b00001);
        chk("halted_cycle", cycle_count, 27);
        chk("halted_freeze6", freeze_count, 6);
        drive(1, 1, 1, 0, 0);
        chk_ctl("halted_ignore_ctl", 5'b00001);
        drive(0, 1, 0, 1, 0);
        chk("halted_cycle_frozen", cycle_count, 27);
        chk("halted_flush_kept", flush_count, 2);
        chk("halted_freeze_kept", freeze_count, 6);

        // Reset during HALTED takes effect immediately
        @(negedge clk);
        reset_n = 1'b0;
        load_use_stall = 0; branch_taken = 0; halt_req = 0; dmem_req = 0; dmem_ready = 0;
        #1;
        chk("rst_halt_halted", halted, 0);
        chk("rst_halt_cycle", cycle_count, 0);
        chk("rst_halt_flush", flush_count, 0);
        chk("rst_halt_freeze", freeze_count, 0);
        chk("rst_halt_stall", stall_count, 0);
        chk_ctl("rst_halt_ctl", 5'b00001);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_ctl("rst_halt_release", 5'b11000);

        // Reset during DRAIN with drain counter at 2
        drive(0, 0, 1, 0, 0);                 // cycle 1: halt accepted
        drive(0, 0, 0, 0, 0);                 // DRAIN, counter 3 -> 2
        chk_ctl("drain2_ctl", 5'b00010);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_ctl("rst_drain_ctl", 5'b00001);
        chk("rst_drain_cycle", cycle_count, 0);
        chk("rst_drain_halted", halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_ctl("rst_drain_release", 5'b11000);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        chk("post_rst_cycle5", cycle_count, 5);
        chk("post_rst_halted0", halted, 0);
        chk_ctl("post_rst_ctl", 5'b11000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
